// File: rtl/video_framebuffer_writer.sv
// Packs a coordinate-tagged pixel stream into Avalon-MM write words and writes
// double-buffered frames using counter-generated addresses, with loss-of-sync recovery.
module video_framebuffer_writer #(
  parameter int AVN_AW    = 19,
  parameter int AVN_DW    = 16,
  parameter int PIX_W     = 8,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int H_W       = 10,
  parameter int V_W       = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                swap_en,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [H_W-1:0]      in_hc,
  input  logic [V_W-1:0]      in_vc,
  input  logic [PIX_W-1:0]    in_pix,
  output logic                avn_write,
  output logic [AVN_AW-1:0]   avn_address,
  output logic [AVN_DW-1:0]   avn_writedata,
  output logic [AVN_DW/8-1:0] avn_byteenable,
  input  logic                avn_waitrequest,
  output logic                disp_buf,
  output logic                frame_done,
  output logic                sync_err
);
  localparam int PPW         = AVN_DW / PIX_W;
  localparam int FRAME_WORDS = H_DISPLAY * V_DISPLAY / PPW;
  localparam int K_W         = (PPW > 1) ? $clog2(PPW) : 1;

  if (H_DISPLAY % PPW != 0) begin : g_bad_h
    $error("H_DISPLAY must be a multiple of PPW");
  end
  if (64'(2 * FRAME_WORDS) > (64'(1) << AVN_AW)) begin : g_bad_aw
    $error("two frame buffers do not fit in the Avalon address space");
  end

  typedef enum logic {SYNC, RUN} state_t;

  state_t              state_q, state_d;
  logic [H_W-1:0]      h_cnt_q, h_cnt_d;
  logic [V_W-1:0]      v_cnt_q, v_cnt_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [AVN_DW-1:0]   pack_q, pack_d;
  logic [AVN_AW-1:0]   word_addr_q, word_addr_d;
  logic                wr_buf_q, wr_buf_d;
  logic                disp_buf_q, disp_buf_d;
  logic                last_q, last_d;
  logic                avn_write_q, avn_write_d;
  logic [AVN_AW-1:0]   avn_address_q, avn_address_d;
  logic [AVN_DW-1:0]   avn_writedata_q, avn_writedata_d;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q, sync_err_d;

  logic                hs, accept, at_origin, match, mismatch, first, take;
  logic                frame_end, wr_buf_nxt;
  logic [K_W-1:0]      cur_k;
  logic [AVN_DW-1:0]   cur_pack;
  logic [AVN_AW-1:0]   cur_waddr;

  assign in_rdy         = !avn_write_q || !avn_waitrequest;
  assign avn_write      = avn_write_q;
  assign avn_address    = avn_address_q;
  assign avn_writedata  = avn_writedata_q;
  assign avn_byteenable = '1;
  assign disp_buf       = disp_buf_q;
  assign frame_done     = frame_done_q;
  assign sync_err       = sync_err_q;

  assign hs         = avn_write_q && !avn_waitrequest;
  assign accept     = in_vld && in_rdy;
  assign at_origin  = (in_hc == '0) && (in_vc == '0);
  assign match      = (in_hc == h_cnt_q) && (in_vc == v_cnt_q);
  assign mismatch   = accept && (state_q == RUN) && !match;
  assign first      = (state_q == SYNC) || !match;
  assign take       = accept && (at_origin || ((state_q == RUN) && match));
  assign frame_end  = hs && last_q;
  // A word emitted in the frame-end cycle already belongs to the next buffer.
  assign wr_buf_nxt = frame_end ? (swap_en ? ~wr_buf_q : 1'b0) : wr_buf_q;

  always_comb begin
    state_d         = state_q;
    h_cnt_d         = h_cnt_q;
    v_cnt_d         = v_cnt_q;
    k_d             = k_q;
    pack_d          = pack_q;
    word_addr_d     = word_addr_q;
    last_d          = last_q;
    avn_write_d     = avn_write_q;
    avn_address_d   = avn_address_q;
    avn_writedata_d = avn_writedata_q;
    disp_buf_d      = disp_buf_q;
    wr_buf_d        = wr_buf_nxt;
    frame_done_d    = frame_end;
    sync_err_d      = mismatch;
    cur_k           = '0;
    cur_pack        = '0;
    cur_waddr       = '0;

    if (hs) begin
      avn_write_d = 1'b0;
      last_d      = 1'b0;
    end
    if (frame_end) disp_buf_d = wr_buf_q;

    if (mismatch) begin
      state_d     = SYNC;
      h_cnt_d     = '0;
      v_cnt_d     = '0;
      k_d         = '0;
      pack_d      = '0;
      word_addr_d = '0;
    end

    if (take) begin
      cur_k     = first ? '0 : k_q;
      cur_pack  = first ? '0 : pack_q;
      cur_waddr = first ? '0 : word_addr_q;
      cur_pack[int'(cur_k)*PIX_W +: PIX_W] = in_pix;
      state_d   = RUN;
      if (in_hc == H_W'(H_DISPLAY - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (in_vc == V_W'(V_DISPLAY - 1)) ? '0 : in_vc + 1'b1;
      end else begin
        h_cnt_d = in_hc + 1'b1;
        v_cnt_d = in_vc;
      end
      if (cur_k == K_W'(PPW - 1)) begin
        avn_write_d     = 1'b1;
        avn_writedata_d = cur_pack;
        avn_address_d   = wr_buf_nxt ? AVN_AW'(FRAME_WORDS) + cur_waddr : cur_waddr;
        last_d          = (cur_waddr == AVN_AW'(FRAME_WORDS - 1));
        word_addr_d     = last_d ? '0 : cur_waddr + 1'b1;
        k_d             = '0;
        pack_d          = '0;
      end else begin
        k_d         = cur_k + 1'b1;
        pack_d      = cur_pack;
        word_addr_d = cur_waddr;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q         <= SYNC;
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      k_q             <= '0;
      pack_q          <= '0;
      word_addr_q     <= '0;
      wr_buf_q        <= 1'b0;
      disp_buf_q      <= 1'b1;
      last_q          <= 1'b0;
      avn_write_q     <= 1'b0;
      avn_address_q   <= '0;
      avn_writedata_q <= '0;
      frame_done_q    <= 1'b0;
      sync_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      k_q             <= k_d;
      pack_q          <= pack_d;
      word_addr_q     <= word_addr_d;
      wr_buf_q        <= wr_buf_d;
      disp_buf_q      <= disp_buf_d;
      last_q          <= last_d;
      avn_write_q     <= avn_write_d;
      avn_address_q   <= avn_address_d;
      avn_writedata_q <= avn_writedata_d;
      frame_done_q    <= frame_done_d;
      sync_err_q      <= sync_err_d;
    end
  end
endmodule
